// File: rtl/fp_add_pkg.sv
// fp_add_pkg: width derivation, lane slicing and saturation limits for fp_add_pipe
package fp_add_pkg;

    localparam int LIM_W = 64;

    typedef enum logic [1:0] {CLAMP_NONE, CLAMP_HI, CLAMP_LO} clamp_e;

    function automatic int max_i(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int align_frac(input int f1, input int f2);
        return max_i(f1, f2);
    endfunction

    function automatic int ideal_int(input int i1, input int i2);
        return max_i(i1, i2) + 1;
    endfunction

    // ideal integer bits plus aligned fraction plus one guard bit keeps a+b and a-b exact
    function automatic int acc_width(input int i1, input int f1, input int i2, input int f2);
        return ideal_int(i1, i2) + align_frac(f1, f2) + 1;
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

    // upper clamp: 0111..1 when signed, 1111..1 when unsigned (n LSBs meaningful)
    function automatic logic [LIM_W-1:0] sat_hi(input int n, input logic sgn);
        return {LIM_W{1'b1}} >> (LIM_W - n + int'(sgn));
    endfunction

    // lower clamp: 1000..0 when signed, 0 when unsigned (n LSBs meaningful)
    function automatic logic [LIM_W-1:0] sat_lo(input int n, input logic sgn);
        return sgn ? {LIM_W{1'b1}} << (n - 1) : '0;
    endfunction

endpackage

// File: rtl/fp_sat_lane.sv
// fp_sat_lane: one lane's fraction reduction and saturation; FP_ADD_PIPE_ROUND_EN enables round half-up
module fp_sat_lane
    import fp_add_pkg::*;
#(
    parameter int W  = 18,
    parameter int FI = 14,
    parameter int I3 = 2,
    parameter int F3 = 14
) (
    input  logic signed [W-1:0] x,
    input  logic                sgn,
    output logic [I3+F3-1:0]    y,
    output logic                sat
);

    localparam int N  = I3 + F3;
    localparam int UP = (F3 > FI) ? F3 - FI : 0;
    localparam int DN = (FI > F3) ? FI - F3 : 0;
    localparam int RW = max_i(W + UP, N + 2);

    logic signed [RW-1:0] r;
    clamp_e clamp;

    generate
        if (DN > 0) begin : g_down
            logic signed [W-1:0] xr;
`ifdef FP_ADD_PIPE_ROUND_EN
            localparam logic signed [W-1:0] HALF = W'(1) <<< (DN - 1);
            // the guard bit absorbs the half-LSB carry, so this cannot wrap
            assign xr = x + HALF;
`else
            assign xr = x;
`endif
            // arithmetic shift truncates toward minus infinity
            assign r = RW'(xr >>> DN);
        end else begin : g_up
            assign r = RW'(x) <<< UP;
        end
    endgenerate

    // out of range when the bits above the result width are not a pure sign/zero extension
    assign clamp = sgn
        ? ((!r[RW-1] && |r[RW-2:N-1]) ? CLAMP_HI : (r[RW-1] && !(&r[RW-2:N-1])) ? CLAMP_LO : CLAMP_NONE)
        : (r[RW-1] ? CLAMP_LO : (|r[RW-2:N]) ? CLAMP_HI : CLAMP_NONE);

    assign y   = (clamp == CLAMP_HI) ? N'(sat_hi(N, sgn)) :
                 (clamp == CLAMP_LO) ? N'(sat_lo(N, sgn)) : r[N-1:0];
    assign sat = clamp != CLAMP_NONE;

endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: two-stage multi-lane fixed-point add/sub with saturation; FP_ADD_PIPE_ROUND_EN selects rounding
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int I1    = 2,
    parameter int F1    = 14,
    parameter int I2    = 2,
    parameter int F2    = 14,
    parameter int I3    = 2,
    parameter int F3    = 14,
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*(I1+F1)-1:0]  a,
    input  logic                      s1,
    input  logic [LANES*(I2+F2)-1:0]  b,
    input  logic                      s2,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*(I3+F3)-1:0]  c,
    output logic                      sign,
    output logic [LANES-1:0]          sat,
    output logic                      sat_sticky,
    input  logic                      clr_sticky
);

    localparam int FI = align_frac(F1, F2);
    localparam int W  = acc_width(I1, F1, I2, F2);
    localparam int WA = I1 + F1;
    localparam int WB = I2 + F2;
    localparam int WC = I3 + F3;

    logic                  s1_full, s1_sign, s1_en, s2_en;
    logic [LANES*W-1:0]    sum, s1_sum;
    logic [LANES*WC-1:0]   c_nxt;
    logic [LANES-1:0]      sat_nxt;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_full || s2_en;
    assign in_ready = s1_en;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [WA-1:0] al;
            logic [WB-1:0] bl;
            logic [W-1:0]  ax, bx;
            assign al = a[lane_lsb(k, WA) +: WA];
            assign bl = b[lane_lsb(k, WB) +: WB];
            assign ax = {{(W-WA){s1 & al[WA-1]}}, al} << (FI - F1);
            assign bx = {{(W-WB){s2 & bl[WB-1]}}, bl} << (FI - F2);
            assign sum[lane_lsb(k, W) +: W] = sub ? ax - bx : ax + bx;
            fp_sat_lane #(.W(W), .FI(FI), .I3(I3), .F3(F3)) u_sat (
                .x   (s1_sum[lane_lsb(k, W) +: W]),
                .sgn (s1_sign),
                .y   (c_nxt[lane_lsb(k, WC) +: WC]),
                .sat (sat_nxt[k])
            );
        end
    endgenerate

    // stage 1: capture the exact aligned sums and result signedness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_sign <= 1'b0;
            s1_sum  <= '0;
        end else if (s1_en) begin
            s1_full <= in_valid;
            s1_sign <= s1 | s2;
            s1_sum  <= sum;
        end
    end

    // stage 2: register reduced/saturated lanes; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sign      <= 1'b0;
            c         <= '0;
            sat       <= '0;
        end else if (s2_en) begin
            out_valid <= s1_full;
            sign      <= s1_sign;
            c         <= c_nxt;
            sat       <= sat_nxt;
        end
    end

    // sticky saturation: a consumed saturated result beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_sticky <= 1'b0;
        else sat_sticky <= (out_valid && out_ready && |sat) ? 1'b1 : clr_sticky ? 1'b0 : sat_sticky;
    end

endmodule
